demux_rr_sched: RTL and testbench

//   Round-robin scheduler/router in front of the 1xN demux datapath. Accepts a

---
 rtl/demux_rr_sched.sv | 131 +++++++++++++
 tb/tb_demux_rr_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler in front of a 1xN demux: one-entry holding register,
// burst-granular channel rotation, per-channel enable mask and back-pressure.
module demux_rr_sched #(
    parameter int N     = 4,
    parameter int DW    = 1,
    parameter int BURST = 2,
    localparam int SELW = $clog2(N),
    localparam int BW   = $clog2(BURST + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    input  logic [N-1:0]    ch_en,
    input  logic [N-1:0]    out_ready,
    output logic [N-1:0]    out_valid,
    output logic [DW-1:0]   out_data,
    output logic [SELW-1:0] sel,
    output logic            en,
    output logic [BW-1:0]   beat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_ROUTE
    } state_t;

    localparam logic [SELW-1:0] SMAX = SELW'(N - 1);
    localparam logic [BW-1:0]   LAST = BW'(BURST - 1);

    state_t          r_state;
    logic [SELW-1:0] r_sel;
    logic [BW-1:0]   r_beat;
    logic            r_full;
    logic [DW-1:0]   r_data;

    state_t          w_state_nxt;
    logic [SELW-1:0] w_sel_nxt;
    logic [SELW-1:0] w_sel_inc;
    logic [BW-1:0]   w_beat_nxt;
    logic            w_full_nxt;
    logic            w_last;
    logic            w_acc;
    logic            w_hs;

    assign w_sel_inc = (r_sel == SMAX) ? '0 : r_sel + 1'b1;
    assign w_last    = (r_beat == LAST);
    assign w_hs      = r_full && out_ready[r_sel];

    // No new word on the last beat: the pointer must move before refilling.
    assign in_ready = (r_state == S_ROUTE) && ch_en[r_sel] &&
                      (!r_full || (out_ready[r_sel] && !w_last));
    assign w_acc    = in_valid && in_ready;

    assign out_valid = r_full ? (N'(1) << r_sel) : '0;
    assign out_data  = r_data;
    assign sel       = r_sel;
    assign en        = r_full;
    assign beat_cnt  = r_beat;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_beat_nxt  = r_beat;
        w_full_nxt  = r_full;

        if (w_acc) begin
            w_full_nxt = 1'b1;
        end
        if (w_hs) begin
            if (w_last) begin
                w_full_nxt = 1'b0;
                w_beat_nxt = '0;
                w_sel_nxt  = w_sel_inc;
            end else begin
                w_beat_nxt = r_beat + 1'b1;
                w_full_nxt = w_acc;
            end
        end

        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = ch_en[r_sel] ? S_ROUTE : S_SKIP;
            end
            S_SKIP: begin
                w_sel_nxt   = w_sel_inc;
                w_beat_nxt  = '0;
                w_state_nxt = ch_en[w_sel_inc] ? S_ROUTE : S_SKIP;
            end
            S_ROUTE: begin
                if (w_hs && w_last) begin
                    w_state_nxt = ch_en[w_sel_inc] ? S_ROUTE : S_SKIP;
                end else if (!r_full && !ch_en[r_sel]) begin
                    w_state_nxt = S_SKIP;
                    w_beat_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Park with the pointer frozen until some channel is enabled again.
        if (!r_full && (ch_en == '0)) begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = r_sel;
            w_beat_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_beat  <= '0;
            r_full  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_beat  <= w_beat_nxt;
            r_full  <= w_full_nxt;
            if (w_acc) begin
                r_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched: BURST=2 main instance plus a BURST=1 one.
module tb_demux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid;
    logic [0:0] in_data;
    logic       in_ready;
    logic [3:0] ch_en;
    logic [3:0] out_ready;
    logic [3:0] out_valid;
    logic [0:0] out_data;
    logic [1:0] sel;
    logic       en;
    logic [1:0] beat_cnt;

    logic       in1_valid;
    logic [0:0] in1_data;
    logic       in1_ready;
    logic [3:0] ch1_en;
    logic [3:0] out1_ready;
    logic [3:0] out1_valid;
    logic [0:0] out1_data;
    logic [1:0] sel1;
    logic       en1;
    logic [0:0] beat1_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    demux_rr_sched #(.N(4), .DW(1), .BURST(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ch_en(ch_en), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .sel(sel), .en(en), .beat_cnt(beat_cnt)
    );

    demux_rr_sched #(.N(4), .DW(1), .BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in1_valid), .in_data(in1_data), .in_ready(in1_ready),
        .ch_en(ch1_en), .out_ready(out1_ready), .out_valid(out1_valid),
        .out_data(out1_data), .sel(sel1), .en(en1), .beat_cnt(beat1_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 1'b0;
        ch_en      = 4'hF;
        out_ready  = 4'hF;
        in1_valid  = 1'b0;
        in1_data   = 1'b1;
        ch1_en     = 4'hF;
        out1_ready = 4'hF;

        #12;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_ir", 32'(in_ready), 0);
        chk("rst_beat", 32'(beat_cnt), 0);
        chk("rst_od", 32'(out_data), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_ir", 32'(in_ready), 1);
        chk("rel_sel", 32'(sel), 0);

        // round robin, all enabled
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        for (int i = 0; i < 13; i++) begin
            int ch;
            int ph;
            ch = (i / 3) % 4;
            ph = i % 3;
            chk("rr_ov", 32'(out_valid), (ph == 2) ? 0 : (1 << ch));
            if (ph != 2) chk("rr_od", 32'(out_data), (ph == 0) ? 1 : 0);
            chk("rr_sel", 32'(sel), (ph == 2) ? ((ch + 1) % 4) : ch);
            chk("rr_ir", 32'(in_ready), (ph == 1) ? 0 : 1);
            in_data = (ph == 0) ? 1'b0 : 1'b1;
            if (i < 12) tick();
        end

        // back-pressure on channel 0
        in_valid  = 1'b0;
        out_ready = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_ov", 32'(out_valid), 1);
            chk("bp_od", 32'(out_data), 1);
            chk("bp_sel", 32'(sel), 0);
            chk("bp_ir", 32'(in_ready), 0);
        end
        out_ready = 4'hF;
        #1;
        chk("bp_rel_ir", 32'(in_ready), 1);
        tick();
        chk("bp_hs_ov", 32'(out_valid), 0);
        chk("bp_hs_beat", 32'(beat_cnt), 1);

        // skip disabled channels
        ch_en = 4'b1010;
        #1;
        chk("sk_ir0", 32'(in_ready), 0);
        tick();
        chk("sk_sel0", 32'(sel), 0);
        chk("sk_beat0", 32'(beat_cnt), 0);
        chk("sk_ir1", 32'(in_ready), 0);
        tick();
        chk("sk_sel1", 32'(sel), 1);
        chk("sk_ir2", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        chk("sk_ov1a", 32'(out_valid), 4'b0010);
        chk("sk_od1a", 32'(out_data), 1);
        chk("sk_ir3", 32'(in_ready), 1);
        in_data = 1'b0;
        tick();
        chk("sk_ov1b", 32'(out_valid), 4'b0010);
        chk("sk_od1b", 32'(out_data), 0);
        chk("sk_beat1", 32'(beat_cnt), 1);
        chk("sk_ir4", 32'(in_ready), 0);
        in_valid = 1'b0;
        tick();
        chk("sk_sel2", 32'(sel), 2);
        chk("sk_ov2", 32'(out_valid), 0);
        chk("sk_ir5", 32'(in_ready), 0);
        tick();
        chk("sk_sel3", 32'(sel), 3);
        chk("sk_ir6", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        chk("sk_ov3a", 32'(out_valid), 4'b1000);
        tick();
        chk("sk_ov3b", 32'(out_valid), 4'b1000);
        chk("sk_ir7", 32'(in_ready), 0);
        in_valid = 1'b0;
        tick();
        chk("sk_wrap0", 32'(sel), 0);
        chk("sk_ir8", 32'(in_ready), 0);
        tick();
        chk("sk_wrap1", 32'(sel), 1);
        chk("sk_ir9", 32'(in_ready), 1);

        // disable channel 1 while its word is held
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        chk("dis_ov0", 32'(out_valid), 4'b0010);
        in_valid  = 1'b0;
        ch_en     = 4'b1000;
        out_ready = 4'b1101;
        #1;
        chk("dis_ir0", 32'(in_ready), 0);
        tick();
        chk("dis_ov1", 32'(out_valid), 4'b0010);
        chk("dis_sel1", 32'(sel), 1);
        chk("dis_od", 32'(out_data), 1);
        out_ready = 4'hF;
        tick();
        chk("dis_ov2", 32'(out_valid), 0);
        chk("dis_beat", 32'(beat_cnt), 1);
        tick();
        chk("dis_sel_a", 32'(sel), 1);
        chk("dis_beat0", 32'(beat_cnt), 0);
        tick();
        chk("dis_sel_b", 32'(sel), 2);
        tick();
        chk("dis_sel_c", 32'(sel), 3);
        chk("dis_ir1", 32'(in_ready), 1);

        // all channels disabled
        ch_en = 4'b0000;
        #1;
        chk("idle_ir0", 32'(in_ready), 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("idle_ir", 32'(in_ready), 0);
            chk("idle_ov", 32'(out_valid), 0);
            chk("idle_sel", 32'(sel), 3);
            tick();
        end
        ch_en = 4'b0100;
        tick();
        chk("wake_sel3", 32'(sel), 3);
        chk("wake_ir0", 32'(in_ready), 0);
        tick();
        tick();
        tick();
        chk("wake_sel2", 32'(sel), 2);
        chk("wake_ir1", 32'(in_ready), 1);

        // asynchronous reset with a word held on channel 2
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        chk("mr_ov", 32'(out_valid), 4'b0100);
        chk("mr_en", 32'(en), 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rst_ov", 32'(out_valid), 0);
        chk("mr_rst_en", 32'(en), 0);
        chk("mr_rst_sel", 32'(sel), 0);
        chk("mr_rst_ir", 32'(in_ready), 0);
        chk("mr_rst_beat", 32'(beat_cnt), 0);
        ch_en = 4'hF;
        #2;
        rst_n = 1'b1;
        tick();
        chk("mr_rel_sel", 32'(sel), 0);
        chk("mr_rel_ir", 32'(in_ready), 1);

        // BURST=1 instance rotating every word
        in1_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("b1_ov", 32'(out1_valid), (i % 2 == 0) ? (1 << ((i / 2) % 4)) : 0);
            chk("b1_sel", 32'(sel1), (i % 2 == 0) ? ((i / 2) % 4) : ((i / 2 + 1) % 4));
            chk("b1_ir", 32'(in1_ready), (i % 2 == 0) ? 0 : 1);
            chk("b1_beat", 32'(beat1_cnt), 0);
        end
        in1_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
